midi_note_parser: RTL and testbench
===================================

Name: midi_note_parser

Overview:
- Monophonic MIDI voice-message parser that sits directly upstream of the note-to-tuning-code lookup.
- Consumes the byte stream from the UART receiver.
- Tracks status and running status, decodes Note On and Note Off for one channel, and holds the current note number. That note number drives the lookup's 7-bit note input.
- Also produces a gate and a velocity for the envelope and output stages.

Parameters:
- CHANNEL, 4'd0, MIDI channel (0-15) whose note messages are accepted.
- OMNI, 1'b0, when 1, accept note messages on all channels and ignore CHANNEL.
- RESET_NOTE, 7'd69, note held on midi_note after reset (A4).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous reset, active-low.
- rx_byte  input  8  received MIDI byte.
- rx_valid  input  1  one-cycle strobe; rx_byte is valid in this cycle.
- midi_note  output  7  current note number; feeds the tuning-code lookup.
- velocity  output  7  velocity of the last accepted Note On.
- gate  output  1  high while the current note is held.
- note_strobe  output  1  one-cycle pulse when a Note On is accepted.
- parse_error  output  1  one-cycle pulse when a data byte arrives with no running status.

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, all state and outputs take reset values.
  - midi_note=RESET_NOTE, velocity=0, gate=0, note_strobe=0, parse_error=0.
  - state=IDLE, running status cleared.
- Bytes are processed only in cycles with rx_valid=1. rx_byte is ignored otherwise.
- Byte classes:
  - Realtime (0xF8-0xFF): ignored entirely. No state change, running status kept, and it may appear between data bytes.
  - System common/exclusive (0xF0-0xF7): clear running status, go to IDLE.
  - Channel status (0x80-0xEF): latch as running status and go to WAIT_D1, even if a message was partly received (the partial message is discarded).
  - Data (0x00-0x7F): handled per state.
- States:
  - IDLE: data byte -> pulse parse_error, stay in IDLE.
  - WAIT_D1: data byte -> latch it as d1.
    - Status 0xC_/0xD_ (one data byte): message is complete, stay in WAIT_D1.
    - Otherwise: go to WAIT_D2.
  - WAIT_D2: data byte -> message complete, act on it, return to WAIT_D1. Running status is retained, so the next data byte starts a new message.
- Acting on a message: only status nibble 0x9 (Note On) or 0x8 (Note Off) whose channel matches CHANNEL (or OMNI=1). All other complete messages are discarded silently.
  - Note On with velocity>0: next cycle midi_note=d1, velocity=d2, gate=1, note_strobe=1 for exactly one cycle.
    - Last-note priority: a new Note On replaces the held note without dropping gate.
  - Note Off, or Note On with velocity=0: gate=0 next cycle only if gate=1 and d1==midi_note.
    - midi_note and velocity are unchanged.
    - An off for a non-current note is ignored.
- Latency: outputs update on the clk edge after the cycle carrying the final data byte, i.e. one cycle.
- midi_note is stable at all times other than on an accepted Note On. The downstream lookup is combinational, so the tuning code changes in the same cycle as midi_note.
- note_strobe and parse_error are never high for more than one consecutive cycle unless the qualifying bytes arrive on consecutive valid cycles.
- Reset asserted mid-message: the partial message is discarded, and the next data byte (without a new status) gives parse_error.
- Back-to-back rx_valid on every cycle must be supported at full rate.

Test Plan:
- Reset, then 0x90,0x3C,0x64 -> one cycle after the third byte: midi_note=60, velocity=100, gate=1, note_strobe pulse of 1 cycle. Before that, midi_note=69, gate=0.
- Running status: 0x90,0x40,0x50 then 0x43,0x20 -> second note: midi_note=67, velocity=32, gate stays 1, two note_strobe pulses total.
- Off matching: hold note 67, send 0x80,0x40,0x00 -> gate stays 1. Then send 0x90,0x43,0x00 -> gate=0, midi_note stays 67.
- Realtime interleave: 0x90,0xF8,0x30,0xFE,0x7F -> midi_note=48, velocity=127, no extra state disturbance.
- Channel filter (CHANNEL=0, OMNI=0): 0x91,0x3C,0x40 -> no change. 0xC0,0x05 then 0x3C -> the program change is discarded; 0x3C is taken as a new one-byte message, so no note change and no parse_error.
- Errors and reset: data byte 0x3C after reset -> parse_error pulse. Send 0x90,0x3C then rst_n low for one cycle, then 0x64 -> parse_error, gate=0, midi_note=69.

Source files
------------

// File: rtl/midi_note_parser.sv
// Monophonic MIDI note parser: status/running-status tracking and
// Note On/Off decode for one channel, driving note, velocity and gate.
module midi_note_parser #(
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter logic       OMNI       = 1'b0,
  parameter logic [6:0] RESET_NOTE = 7'd69
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [6:0] midi_note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_strobe,
  output logic       parse_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] status, status_n;
  logic [6:0] d1, d1_n;
  logic [6:0] note_n, vel_n;
  logic       gate_n, strobe_n, err_n;

  logic is_rt, is_sys, is_chan, is_data;
  logic ch_ok, is_on, is_off;

  assign is_rt   = &rx_byte[7:3];
  assign is_sys  = (rx_byte[7:4] == 4'hF) && !rx_byte[3];
  assign is_chan = rx_byte[7] && (rx_byte[7:4] != 4'hF);
  assign is_data = !rx_byte[7];

  assign ch_ok  = OMNI || (status[3:0] == CHANNEL);
  assign is_on  = ch_ok && (status[7:4] == 4'h9)
                  && (rx_byte[6:0] != 7'd0);
  assign is_off = ch_ok && ((status[7:4] == 4'h8)
                  || ((status[7:4] == 4'h9)
                  && (rx_byte[6:0] == 7'd0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      status      <= 8'd0;
      d1          <= 7'd0;
      midi_note   <= RESET_NOTE;
      velocity    <= 7'd0;
      gate        <= 1'b0;
      note_strobe <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      state       <= state_n;
      status      <= status_n;
      d1          <= d1_n;
      midi_note   <= note_n;
      velocity    <= vel_n;
      gate        <= gate_n;
      note_strobe <= strobe_n;
      parse_error <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    status_n = status;
    d1_n     = d1;
    note_n   = midi_note;
    vel_n    = velocity;
    gate_n   = gate;
    strobe_n = 1'b0;
    err_n    = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        is_rt: begin
        end
        is_sys: begin
          status_n = 8'd0;
          state_n  = IDLE;
        end
        is_chan: begin
          status_n = rx_byte;
          state_n  = WAIT_D1;
        end
        is_data: begin
          unique case (state)
            IDLE: err_n = 1'b1;
            WAIT_D1: begin
              d1_n = rx_byte[6:0];
              // Program change / channel pressure end after one byte
              if (status[7:5] != 3'b110)
                state_n = WAIT_D2;
            end
            WAIT_D2: begin
              state_n = WAIT_D1;
              if (is_on) begin
                note_n   = d1;
                vel_n    = rx_byte[6:0];
                gate_n   = 1'b1;
                strobe_n = 1'b1;
              end else if (is_off && gate && (d1 == midi_note)) begin
                gate_n = 1'b0;
              end
            end
            default: state_n = IDLE;
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench for midi_note_parser: expected output events are
// queued as bytes are sent and matched when the DUT reacts.
module tb_midi_note_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic [6:0] midi_note, velocity;
  logic       gate, note_strobe, parse_error;

  typedef struct {
    logic [6:0] note;
    logic [6:0] vel;
    logic       gate;
    logic       strobe;
    logic       err;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  logic pg = 1'b0;

  always #5 clk = ~clk;

  midi_note_parser dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .midi_note(midi_note),
    .velocity(velocity),
    .gate(gate),
    .note_strobe(note_strobe),
    .parse_error(parse_error)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [6:0] n, input logic [6:0] v,
                      input logic g, input logic s, input logic e);
    ev_t x;
    x.note = n; x.vel = v; x.gate = g; x.strobe = s; x.err = e;
    q.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
    end
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Any strobe, error or gate edge is an output event to match
  always @(negedge clk) begin
    if (!rst_n) begin
      pg = gate;
    end else if (note_strobe || parse_error || (gate !== pg)) begin
      pg = gate;
      if (q.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_note", 32'(midi_note), 32'(e.note));
        chk("ev_vel", 32'(velocity), 32'(e.vel));
        chk("ev_gate", 32'(gate), 32'(e.gate));
        chk("ev_strobe", 32'(note_strobe), 32'(e.strobe));
        chk("ev_err", 32'(parse_error), 32'(e.err));
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk("rst_note", 32'(midi_note), 32'd69);
    chk("rst_vel", 32'(velocity), 32'd0);
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_strobe", 32'(note_strobe), 32'd0);
    chk("rst_err", 32'(parse_error), 32'd0);

    send(8'h90); send(8'h3C); idle(1);
    chk("pre_note", 32'(midi_note), 32'd69);
    chk("pre_gate", 32'(gate), 32'd0);
    push(7'd60, 7'd100, 1'b1, 1'b1, 1'b0);
    send(8'h64); idle(2);

    send(8'h90); send(8'h40);
    push(7'd64, 7'd80, 1'b1, 1'b1, 1'b0);
    send(8'h50);
    send(8'h43);
    push(7'd67, 7'd32, 1'b1, 1'b1, 1'b0);
    send(8'h20); idle(2);

    send(8'h80); send(8'h40); send(8'h00); idle(2);
    chk("off_other_gate", 32'(gate), 32'd1);
    send(8'h90); send(8'h43);
    push(7'd67, 7'd32, 1'b0, 1'b0, 1'b0);
    send(8'h00); idle(2);

    send(8'h90); send(8'hF8); send(8'h30); send(8'hFE);
    push(7'd48, 7'd127, 1'b1, 1'b1, 1'b0);
    send(8'h7F); idle(2);
    send(8'h80); send(8'h30);
    push(7'd48, 7'd127, 1'b0, 1'b0, 1'b0);
    send(8'h00); idle(2);

    send(8'h91); send(8'h3C); send(8'h40);
    send(8'hC0); send(8'h05); send(8'h3C); idle(3);
    chk("filt_note", 32'(midi_note), 32'd48);
    chk("filt_gate", 32'(gate), 32'd0);

    send(8'hF0); send(8'h3C);
    push(7'd48, 7'd127, 1'b0, 1'b0, 1'b1);
    idle(2);

    do_rst();
    push(7'd69, 7'd0, 1'b0, 1'b0, 1'b1);
    send(8'h3C); idle(2);

    send(8'h90); send(8'h3C);
    do_rst();
    push(7'd69, 7'd0, 1'b0, 1'b0, 1'b1);
    send(8'h64); idle(3);
    chk("mid_rst_gate", 32'(gate), 32'd0);
    chk("mid_rst_note", 32'(midi_note), 32'd69);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
